// File: rtl/banked_ram.sv
// Multi-port, bank-interleaved RAM with per-bank round-robin arbitration; 1-cycle response latency.
// Losers of a bank conflict see req_ready=0 and must hold; responses have no backpressure.
module banked_ram #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 8,
  parameter int NPORTS         = 2,
  parameter int BANK_BITS      = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NPORTS-1:0]            req_valid,
  output logic [NPORTS-1:0]            req_ready,
  input  logic [NPORTS-1:0]            req_we,
  input  logic [NPORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NPORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NPORTS-1:0]            rsp_valid,
  output logic [NPORTS*DATA_WIDTH-1:0] rsp_rdata,
  output logic                         init_done
);

  localparam int NBANKS   = 1 << BANK_BITS;
  localparam int ROW_BITS = ADDR_WIDTH - BANK_BITS;
  localparam int PW       = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int BW       = (BANK_BITS > 0) ? BANK_BITS : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  logic [ROW_BITS-1:0]   row_cnt;
  logic [PW-1:0]         rr     [NBANKS];
  logic [PW-1:0]         rr_nxt [NBANKS];
  logic [NPORTS-1:0]     gnt;
  logic [DATA_WIDTH-1:0] mem    [1 << ADDR_WIDTH];

  // Banks are the low address bits, so the array is indexed by the full word address.
  always_comb begin
    logic found;
    logic hit;
    int   idx;
    gnt   = '0;
    found = 1'b0;
    hit   = 1'b0;
    idx   = 0;
    for (int b = 0; b < NBANKS; b++) begin
      rr_nxt[b] = rr[b];
      found     = 1'b0;
      for (int i = 0; i < NPORTS; i++) begin
        idx = int'(rr[b]) + i;
        if (idx >= NPORTS) idx = idx - NPORTS;
        hit = (BANK_BITS == 0) || (req_addr[idx*ADDR_WIDTH +: BW] == BW'(b));
        if (!found && rst_n && state == RUN && req_valid[idx] && hit) begin
          found     = 1'b1;
          gnt[idx]  = 1'b1;
          rr_nxt[b] = (idx == NPORTS - 1) ? '0 : PW'(idx + 1);
        end
      end
    end
  end

  assign req_ready = gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      row_cnt   <= '0;
      init_done <= (CLEAR_ON_RESET == 0);
      rsp_valid <= '0;
      rsp_rdata <= '0;
      for (int b = 0; b < NBANKS; b++) rr[b] <= '0;
    end else begin
      if (state == CLEAR) begin
        row_cnt <= row_cnt + 1'b1;
        if (row_cnt == '1) begin
          state     <= RUN;
          init_done <= 1'b1;
        end
      end
      rsp_valid <= gnt;
      for (int b = 0; b < NBANKS; b++) rr[b] <= rr_nxt[b];
      for (int p = 0; p < NPORTS; p++) begin
        if (gnt[p])
          rsp_rdata[p*DATA_WIDTH +: DATA_WIDTH] <=
            req_we[p] ? '0 : mem[req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

  // At most one grant per bank, so every bank sees at most one write per cycle.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      for (int b = 0; b < NBANKS; b++)
        mem[(ADDR_WIDTH'(row_cnt) << BANK_BITS) | ADDR_WIDTH'(b)] <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (gnt[p] && req_we[p])
          mem[req_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: doc/banked_ram.md
# banked_ram

Parametrised multi-port, bank-interleaved synchronous RAM. It is the successor to the two-port system RAM. Unlike that block, all ports share one address space; the number of ports and banks is configurable; every port uses a valid/ready handshake; per-bank round-robin arbitration resolves conflicts; and an optional post-reset clear sequence zeroes the whole array. It serves as the system memory shared by the fetch, load/store and DMA-style agents of the core.

## Interface
Parameters:
- ADDR_WIDTH, 10: word address width; total depth 2^ADDR_WIDTH words.
- DATA_WIDTH, 8: word width in bits.
- NPORTS, 2: number of request ports (≥1).
- BANK_BITS, 1: log2 of bank count (0 ≤ BANK_BITS < ADDR_WIDTH); NBANKS = 2^BANK_BITS.
- CLEAR_ON_RESET, 1: 1 = zero all words after reset; 0 = memory contents undefined, ready immediately.

Ports (port p occupies slice [p*W +: W] of each flat vector):
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NPORTS  request present.
- req_ready  out  NPORTS  request accepted this cycle.
- req_we  in  NPORTS  1 = write, 0 = read.
- req_addr  in  NPORTS*ADDR_WIDTH  word address.
- req_wdata  in  NPORTS*DATA_WIDTH  write data.
- rsp_valid  out  NPORTS  response for request accepted previous cycle.
- rsp_rdata  out  NPORTS*DATA_WIDTH  read data; 0 on write acks.
- init_done  out  1  high once clear sequence finished.

## Operation
- Address split: bank = addr[BANK_BITS-1:0], row = addr[ADDR_WIDTH-1:BANK_BITS]; each bank is 2^(ADDR_WIDTH-BANK_BITS) rows. With BANK_BITS = 0 there is a single bank.
- FSM states: CLEAR, RUN.
- Reset: state = CLEAR if CLEAR_ON_RESET, else RUN. Reset also clears the row counter to 0, all round-robin pointers to 0, rsp_valid to 0, rsp_rdata to 0 and init_done to CLEAR_ON_RESET ? 0 : 1.
- CLEAR state:
  - Every bank writes 0 at the row counter each cycle; the counter increments.
  - After the last row is written, state goes to RUN and init_done rises.
  - req_ready = 0 for every port throughout.
- RUN state, per bank:
  - Candidates are ports with req_valid whose address selects that bank.
  - The grant goes to the first candidate found searching upward (with wrap) from rr[bank].
  - On a grant, rr[bank] = granted port + 1 mod NPORTS. With no grant, rr[bank] is unchanged.
- A port's req_ready = 1 iff it is granted in its bank. Different banks grant independently, so up to min(NPORTS, NBANKS) accesses can occur per cycle.
- Accepted read: rsp_rdata[p] <= bank[row] (value before any write this cycle; writes to that same row this cycle are impossible because only one port per bank is granted).
- Accepted write: bank[row] <= wdata; rsp_rdata[p] <= 0.
- Handshake rules:
  - req_ready may depend combinationally on any req_valid/req_addr.
  - req_valid must not depend on req_ready.
  - The requester holds we/addr/wdata stable while valid && !ready.
- No response backpressure: the requester must accept rsp_valid whenever it is asserted.
- Write-then-read of the same address on consecutive accepted cycles returns the new data.
- Reset asserted mid-operation:
  - In-flight responses are dropped (rsp_valid = 0 next cycle).
  - Array contents are kept if CLEAR_ON_RESET = 0, otherwise re-cleared.
  - Reset during CLEAR restarts the clear at row 0.

## Timing
- Clear duration: 2^(ADDR_WIDTH-BANK_BITS) cycles after rst_n deassertion; 512 cycles at defaults. init_done is high in the cycle after the last clear write.
- Latency: a request accepted at edge t gives rsp_valid = 1 for exactly the cycle following t, with rsp_rdata valid in that cycle.
- Throughput: 1 request per port per cycle when there is no bank conflict.
- Fairness: with k ports contending for one bank continuously, each port is granted at least once in any k consecutive cycles.
- rsp_rdata holds its last value while rsp_valid = 0.

## Test plan
- Reset clear, defaults: hold rst_n low 2 cycles, release. Required: init_done = 0 and all req_ready = 0 for 512 cycles, then init_done = 1; reads of addresses 0, 511 and 1023 all return 0x00.
- Basic write/read: port0 writes 0xA5 to 0x012 at cycle t, reads 0x012 at t+1. Required: rsp_valid0 high at t+1 with rdata 0; rsp_valid0 high at t+2 with rdata 0xA5.
- Parallel banks: port0 reads 0x010 (bank 0) while port1 reads 0x021 (bank 1) in the same cycle. Required: both ready = 1 and both respond next cycle with the stored data.
- Conflict/round-robin: both ports hold a read of bank 0 (0x002, 0x004) for 4 cycles. Required: grants alternate p0, p1, p0, p1 starting from p0 after reset; the loser sees ready = 0 and holds its request.
- Reset mid-traffic: assert rst_n low in the cycle after an accepted read. Required: rsp_valid = 0 the following cycle; the clear restarts and init_done = 0 for 512 cycles.
- CLEAR_ON_RESET=0, NPORTS=3, BANK_BITS=0: all 3 ports request every cycle. Required: init_done = 1 immediately and ready rotates p0, p1, p2, p0.
